// File: rtl/slc3_mem_arbiter.sv
// slc3_mem_arbiter: round-robin arbiter and access sequencer between the
// SLC-3 core (cpu_*) and the debug/program-loader port (dbg_*) sharing a
// single SRAM/Mem2IO port. Each transaction is IDLE -> ACCESS (N cycles of
// mem_oe or mem_we) -> DONE (one-cycle done pulse to the owner).
module slc3_mem_arbiter #(
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] dbg_rdata,
  output logic        dbg_done,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_oe,
  output logic        mem_we,
  output logic        busy,
  output logic        owner_dbg
);

  localparam logic [3:0] READ_CNT  = 4'(READ_WAIT);
  localparam logic [3:0] WRITE_CNT = 4'(WRITE_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        last_owner;
  logic        we_q;
  logic        grant_dbg;

  // Round-robin choice: a lone request wins; on a tie the port that did not
  // own the previous transaction wins.
  always_comb begin
    grant_dbg = 1'b0;
    if (cpu_req && dbg_req) begin
      grant_dbg = ~last_owner;
    end else begin
      grant_dbg = dbg_req;
    end
  end

  // Transaction sequencer with registered memory-port and handshake outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      owner_dbg  <= 1'b0;
      busy       <= 1'b0;
      mem_oe     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_done   <= 1'b0;
      dbg_done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req || dbg_req) begin
            state      <= S_ACCESS;
            busy       <= 1'b1;
            owner_dbg  <= grant_dbg;
            last_owner <= grant_dbg;
            if (grant_dbg) begin
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
              we_q      <= dbg_we;
              mem_oe    <= ~dbg_we;
              mem_we    <= dbg_we;
              cnt       <= dbg_we ? WRITE_CNT : READ_CNT;
            end else begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              we_q      <= cpu_we;
              mem_oe    <= ~cpu_we;
              mem_we    <= cpu_we;
              cnt       <= cpu_we ? WRITE_CNT : READ_CNT;
            end
          end
        end
        S_ACCESS: begin
          cnt <= cnt - 4'd1;
          // Enables are registered, so they are cleared on the same edge that
          // captures read data; this keeps them high for exactly N cycles.
          if (cnt <= 4'd1) begin
            state  <= S_DONE;
            mem_oe <= 1'b0;
            mem_we <= 1'b0;
            if (!we_q) begin
              if (owner_dbg) begin
                dbg_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
            if (owner_dbg) begin
              dbg_done <= 1'b1;
            end else begin
              cpu_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          cpu_done <= 1'b0;
          dbg_done <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Scoreboard bench for slc3_mem_arbiter: stimulus pushes expected
// transactions, a negedge monitor checks every enable and done cycle.
module tb_slc3_mem_arbiter;

  logic        Clk;
  logic        Reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        cpu_done, dbg_done;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_oe, mem_we, busy, owner_dbg;

  slc3_mem_arbiter #(.READ_WAIT(2), .WRITE_WAIT(1)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe(mem_oe), .mem_we(mem_we), .busy(busy), .owner_dbg(owner_dbg)
  );

  // Memory model: 0x0040 holds 0x1234, everything else reads addr ^ 0xA5A5.
  assign mem_rdata = (mem_addr == 16'h0040) ? 16'h1234 : (mem_addr ^ 16'hA5A5);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        dbg;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int unsigned n;
    int unsigned gap;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic d, input logic w, input logic [15:0] a,
                               input logic [15:0] wd, input logic [15:0] rd,
                               input int unsigned gap);
    exp_t e;
    e.dbg = d; e.we = w; e.addr = a; e.wdata = wd; e.rdata = rd;
    e.n = w ? 1 : 2;
    e.gap = gap;
    sb.push_back(e);
  endfunction

  // Monitor state
  int          cyc = 0;
  int          last_done_cyc = 0;
  int unsigned busy_cnt = 0;
  int unsigned en_cnt = 0;
  logic        prev_done = 1'b0;
  logic [15:0] m_cpu = '0;
  logic [15:0] m_dbg = '0;

  // Monitor: checks the port during enable cycles and each done pulse.
  always @(negedge Clk) begin
    exp_t e;
    cyc++;
    if (Reset) begin
      sb.delete();
      busy_cnt  = 0;
      en_cnt    = 0;
      prev_done = 1'b0;
      m_cpu     = '0;
      m_dbg     = '0;
    end else begin
      if (prev_done) check("done_width", {15'd0, cpu_done | dbg_done}, 16'd0);
      if (busy) busy_cnt++;
      if (mem_oe | mem_we) begin
        en_cnt++;
        if (sb.size() == 0) begin
          check("enable_without_txn", {15'd0, mem_oe | mem_we}, 16'd0);
        end else begin
          check("mem_addr", mem_addr, sb[0].addr);
          check("mem_we_dir", {14'd0, mem_we, mem_oe}, sb[0].we ? 16'd2 : 16'd1);
          if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wdata);
        end
      end
      if (cpu_done | dbg_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {14'd0, cpu_done, dbg_done}, 16'd0);
        end else begin
          e = sb.pop_front();
          check("done_port", {14'd0, cpu_done, dbg_done}, e.dbg ? 16'd1 : 16'd2);
          check("owner_dbg", {15'd0, owner_dbg}, {15'd0, e.dbg});
          check("enable_cycles", 16'(en_cnt), 16'(e.n));
          check("busy_cycles", 16'(busy_cnt), 16'(e.n + 1));
          if (!e.we) begin
            if (e.dbg) m_dbg = e.rdata;
            else m_cpu = e.rdata;
          end
          check("cpu_rdata", cpu_rdata, m_cpu);
          check("dbg_rdata", dbg_rdata, m_dbg);
          if (e.gap != 0) check("done_gap", 16'(cyc - last_done_cyc), 16'(e.gap));
        end
        last_done_cyc = cyc;
        busy_cnt = 0;
        en_cnt   = 0;
        prev_done = 1'b1;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  task automatic wait_dones(input int k, output int cycles);
    int n;
    n = 0;
    cycles = 0;
    while (n < k && cycles < 100) begin
      @(negedge Clk);
      cycles++;
      if (cpu_done | dbg_done) n++;
    end
    if (n < k) check("done_timeout", 16'(n), 16'(k));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    Reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_mem_oe", {15'd0, mem_oe}, 16'd0);
    check("rst_mem_we", {15'd0, mem_we}, 16'd0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_rdata", cpu_rdata | dbg_rdata, 16'h0000);
    check("rst_done", {14'd0, cpu_done, dbg_done}, 16'd0);
    check("rst_busy_owner", {14'd0, busy, owner_dbg}, 16'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Continuous dual reads: CPU, dbg, CPU, dbg, done pulses 4 cycles apart.
    @(posedge Clk); #1;
    cpu_addr = 16'h0100; dbg_addr = 16'h0200;
    cpu_req = 1; dbg_req = 1;
    push(0, 0, 16'h0100, 16'h0000, 16'hA4A5, 0);
    push(1, 0, 16'h0200, 16'h0000, 16'hA7A5, 4);
    push(0, 0, 16'h0100, 16'h0000, 16'hA4A5, 4);
    push(1, 0, 16'h0200, 16'h0000, 16'hA7A5, 4);
    wait_dones(1, lat);
    check("dual_first_latency", 16'(lat), 16'd4);
    wait_dones(3, lat);
    @(posedge Clk); #1;
    cpu_req = 0; dbg_req = 0;
    repeat (3) @(posedge Clk);

    // Single CPU read of 0x0040.
    #1;
    cpu_addr = 16'h0040; cpu_req = 1;
    push(0, 0, 16'h0040, 16'h0000, 16'h1234, 0);
    wait_dones(1, lat);
    check("cpu_read_latency", 16'(lat), 16'd4);
    @(posedge Clk); #1;
    cpu_req = 0;
    @(negedge Clk);
    check("idle_addr_hold", mem_addr, 16'h0040);

    // dbg write of 0xBEEF to 0x3000.
    @(posedge Clk); #1;
    dbg_we = 1; dbg_addr = 16'h3000; dbg_wdata = 16'hBEEF; dbg_req = 1;
    push(1, 1, 16'h3000, 16'hBEEF, 16'h0000, 0);
    wait_dones(1, lat);
    check("dbg_write_latency", 16'(lat), 16'd3);
    @(posedge Clk); #1;
    dbg_req = 0; dbg_we = 0;
    @(negedge Clk);
    check("idle_wdata_hold", mem_wdata, 16'hBEEF);

    // CPU read whose address changes after the grant edge.
    @(posedge Clk); #1;
    cpu_addr = 16'h0010; cpu_req = 1;
    push(0, 0, 16'h0010, 16'h0000, 16'hA5B5, 0);
    @(posedge Clk); #1;
    cpu_addr = 16'h0020;
    wait_dones(1, lat);
    @(posedge Clk); #1;
    cpu_req = 0;
    repeat (2) @(posedge Clk);

    // Reset in the second ACCESS cycle of a dbg read.
    #1;
    dbg_addr = 16'h0200; dbg_req = 1;
    push(1, 0, 16'h0200, 16'h0000, 16'hA7A5, 0);
    @(posedge Clk);
    @(posedge Clk); #1;
    check("oe_before_reset", {15'd0, mem_oe}, 16'd1);
    Reset = 1; dbg_req = 0;
    #1;
    check("oe_async_drop", {15'd0, mem_oe}, 16'd0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 0;
    #1;
    check("post_rst_dbg_rdata", dbg_rdata, 16'h0000);
    check("post_rst_owner", {15'd0, owner_dbg}, 16'd0);

    // Tie right after reset: CPU must win because last_owner resets to dbg.
    @(posedge Clk); #1;
    cpu_addr = 16'h0040; dbg_addr = 16'h0200;
    cpu_req = 1; dbg_req = 1;
    push(0, 0, 16'h0040, 16'h0000, 16'h1234, 0);
    push(1, 0, 16'h0200, 16'h0000, 16'hA7A5, 4);
    wait_dones(1, lat);
    @(posedge Clk); #1;
    cpu_req = 0;
    wait_dones(1, lat);
    @(posedge Clk); #1;
    dbg_req = 0;
    repeat (4) @(posedge Clk);
    check("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
